// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// One operation in flight; the result returns with the owner's ID on a valid/ready channel.
module alu_arbiter #(
    parameter int XLEN        = 32,
    parameter int ALU_LATENCY = 1   // legal range 1..4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [2:0]      r0_fun3,
    input  logic [6:0]      r0_func7,
    input  logic [XLEN-1:0] r0_in1,
    input  logic [XLEN-1:0] r0_in2,

    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [2:0]      r1_fun3,
    input  logic [6:0]      r1_func7,
    input  logic [XLEN-1:0] r1_in1,
    input  logic [XLEN-1:0] r1_in2,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,

    output logic [2:0]      alu_fun3,
    output logic [6:0]      alu_func7,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_out,

    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Producers hold valid and payload stable until ready; ready never waits on valid
    // of the same channel being dropped, and rsp_ready without rsp_valid is ignored.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    logic [1:0]      state;
    logic            rr_ptr;
    logic [2:0]      cnt;

    logic            gnt_valid;
    logic            gnt_id;
    logic [2:0]      sel_fun3;
    logic [6:0]      sel_func7;
    logic [XLEN-1:0] sel_in1;
    logic [XLEN-1:0] sel_in2;

    // Grant depends only on state, valids and rr_ptr, so it is stable while inputs are.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state == IDLE) begin
            if (r0_valid && r1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = rr_ptr;
            end else if (r0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (r1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign r0_ready  = gnt_valid && !gnt_id;
    assign r1_ready  = gnt_valid &&  gnt_id;
    assign dbg_state = state;

    always_comb begin
        sel_fun3  = r0_fun3;
        sel_func7 = r0_func7;
        sel_in1   = r0_in1;
        sel_in2   = r0_in2;
        if (gnt_id) begin
            sel_fun3  = r1_fun3;
            sel_func7 = r1_func7;
            sel_in1   = r1_in1;
            sel_in2   = r1_in2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            cnt       <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            alu_fun3  <= 3'd0;
            alu_func7 <= 7'd0;
            alu_in1   <= '0;
            alu_in2   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        alu_fun3  <= sel_fun3;
                        alu_func7 <= sel_func7;
                        alu_in1   <= sel_in1;
                        alu_in2   <= sel_in2;
                        rsp_id    <= gnt_id;
                        rr_ptr    <= !gnt_id;
                        cnt       <= LAT;
                        state     <= BUSY;
                    end
                end
                // Counter runs LAT..0; capturing on the zero edge gives ALU_LATENCY+1 cycles.
                BUSY: begin
                    if (cnt == 3'd0) begin
                        rsp_data  <= alu_out;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a reference model.
// A small registered ALU stub stands in for the shared ALU on each instance.
module tb_alu_arbiter;

    localparam int L  = 1;
    localparam int L3 = 3;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [2:0]  r0_fun3, r1_fun3;
    logic [6:0]  r0_func7, r1_func7;
    logic [31:0] r0_in1, r0_in2, r1_in1, r1_in2;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic [2:0]  alu_fun3;
    logic [6:0]  alu_func7;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [1:0]  dbg_state;

    logic        l3_r0_valid, l3_r0_ready, l3_r1_valid, l3_r1_ready;
    logic [2:0]  l3_r0_fun3, l3_r1_fun3;
    logic [6:0]  l3_r0_func7, l3_r1_func7;
    logic [31:0] l3_r0_in1, l3_r0_in2, l3_r1_in1, l3_r1_in2;
    logic        l3_rsp_valid, l3_rsp_ready, l3_rsp_id;
    logic [31:0] l3_rsp_data;
    logic [2:0]  l3_alu_fun3;
    logic [6:0]  l3_alu_func7;
    logic [31:0] l3_alu_in1, l3_alu_in2, l3_alu_out;
    logic [1:0]  l3_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return f7[5] ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    logic [31:0] pipe1 [4];
    logic [31:0] pipe3 [4];
    always @(posedge clk) begin
        pipe1[0] <= alu_ref(alu_fun3, alu_func7, alu_in1, alu_in2);
        pipe3[0] <= alu_ref(l3_alu_fun3, l3_alu_func7, l3_alu_in1, l3_alu_in2);
        for (int i = 1; i < 4; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe3[i] <= pipe3[i-1];
        end
    end
    assign alu_out    = pipe1[L-1];
    assign l3_alu_out = pipe3[L3-1];

    alu_arbiter #(.XLEN(32), .ALU_LATENCY(L)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_fun3(r0_fun3), .r0_func7(r0_func7),
        .r0_in1(r0_in1), .r0_in2(r0_in2),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_fun3(r1_fun3), .r1_func7(r1_func7),
        .r1_in1(r1_in1), .r1_in2(r1_in2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_fun3(alu_fun3), .alu_func7(alu_func7), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .dbg_state(dbg_state)
    );

    alu_arbiter #(.XLEN(32), .ALU_LATENCY(L3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(l3_r0_valid), .r0_ready(l3_r0_ready), .r0_fun3(l3_r0_fun3),
        .r0_func7(l3_r0_func7), .r0_in1(l3_r0_in1), .r0_in2(l3_r0_in2),
        .r1_valid(l3_r1_valid), .r1_ready(l3_r1_ready), .r1_fun3(l3_r1_fun3),
        .r1_func7(l3_r1_func7), .r1_in1(l3_r1_in1), .r1_in2(l3_r1_in2),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_id(l3_rsp_id),
        .rsp_data(l3_rsp_data),
        .alu_fun3(l3_alu_fun3), .alu_func7(l3_alu_func7), .alu_in1(l3_alu_in1),
        .alu_in2(l3_alu_in2), .alu_out(l3_alu_out), .dbg_state(l3_dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        r0_valid = 0; r0_fun3 = 0; r0_func7 = 0; r0_in1 = 0; r0_in2 = 0;
        r1_valid = 0; r1_fun3 = 0; r1_func7 = 0; r1_in1 = 0; r1_in2 = 0;
        rsp_ready = 0;
        l3_r0_valid = 0; l3_r0_fun3 = 0; l3_r0_func7 = 0; l3_r0_in1 = 0; l3_r0_in2 = 0;
        l3_r1_valid = 0; l3_r1_fun3 = 0; l3_r1_func7 = 0; l3_r1_in1 = 0; l3_r1_in2 = 0;
        l3_rsp_ready = 0;
    endtask

    // Leaves time at 1ns after a rising edge with reset released.
    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic set_r0(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        r0_valid = 1; r0_fun3 = f3; r0_func7 = f7; r0_in1 = a; r0_in2 = b;
    endtask

    task automatic set_r1(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        r1_valid = 1; r1_fun3 = f3; r1_func7 = f7; r1_in1 = a; r1_in2 = b;
    endtask

    // Waits for a grant, counts edges from accept to rsp_valid, then consumes the response.
    task automatic serve(output logic w, output logic rid, output logic [31:0] d,
                         output int lat, output bit ok);
        int k;
        ok = 0; w = 0; rid = 0; d = '0; lat = 0;
        k = 0;
        #1;
        while (!(r0_ready || r1_ready) && k < 20) begin
            @(posedge clk); #2;
            k++;
        end
        if (!(r0_ready || r1_ready)) return;
        w = r1_ready;
        @(posedge clk); #1;
        if (w) r1_valid = 0; else r0_valid = 0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!rsp_valid) return;
        lat = k; d = rsp_data; rid = rsp_id;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        ok = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++; if ({rsp_id, rsp_data} !== 33'd0) $display("FAIL reset_rsp: got id %b data %0h expected 0/0", rsp_id, rsp_data); else n_pass++;
        n_checks++; if ({alu_fun3, alu_func7, alu_in1, alu_in2} !== 74'd0)
            $display("FAIL reset_alu: got %0h %0h %0h %0h expected all 0", alu_fun3, alu_func7, alu_in1, alu_in2); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
        n_checks++; if ({l3_rsp_valid, l3_dbg_state} !== 3'd0) $display("FAIL reset_l3: got %b/%0d expected 0/0", l3_rsp_valid, l3_dbg_state); else n_pass++;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic w, rid; logic [31:0] d; int lat; bit ok;
        apply_reset();
        set_r0(3'b000, 7'b0000000, 32'd5, 32'd7);
        #1;
        n_checks++; if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL single_grant: got %b expected 10", {r0_ready, r1_ready}); else n_pass++;
        #1;
        serve(w, rid, d, lat, ok);
        n_checks++; if (!ok) $display("FAIL single_timeout: got no response expected one"); else n_pass++;
        n_checks++; if (lat != L + 1) $display("FAIL single_latency: got %0d expected %0d", lat, L + 1); else n_pass++;
        n_checks++; if (d !== 32'd12 || rid !== 1'b0) $display("FAIL single_rsp: got id %b data %0h expected 0/c", rid, d); else n_pass++;
        n_checks++; if ({alu_fun3, alu_in1, alu_in2} !== {3'd0, 32'd5, 32'd7})
            $display("FAIL single_alu_hold: got %0h %0h %0h expected 0 5 7", alu_fun3, alu_in1, alu_in2); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL single_idle: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
    endtask

    task automatic test_two_requesters();
        logic w, rid; logic [31:0] d; int lat; bit ok;
        apply_reset();
        set_r0(3'b000, 7'b0100000, 32'd5, 32'd7);
        set_r1(3'b001, 7'b0000000, 32'd5, 32'd7);
        serve(w, rid, d, lat, ok);
        n_checks++; if (!ok || rid !== 1'b0 || d !== 32'hFFFF_FFFE)
            $display("FAIL two_first: got ok %0d id %b data %0h expected id 0 data fffffffe", ok, rid, d); else n_pass++;
        serve(w, rid, d, lat, ok);
        n_checks++; if (!ok || rid !== 1'b1 || d !== 32'd640)
            $display("FAIL two_second: got ok %0d id %b data %0h expected id 1 data 280", ok, rid, d); else n_pass++;
        set_r0(3'b000, 7'b0000000, 32'd1, 32'd2);
        set_r1(3'b110, 7'b0000000, 32'd8, 32'd1);
        serve(w, rid, d, lat, ok);
        n_checks++; if (!ok || rid !== 1'b0 || d !== 32'd3)
            $display("FAIL two_alt_first: got ok %0d id %b data %0h expected id 0 data 3", ok, rid, d); else n_pass++;
        serve(w, rid, d, lat, ok);
        n_checks++; if (!ok || rid !== 1'b1 || d !== 32'd9)
            $display("FAIL two_alt_second: got ok %0d id %b data %0h expected id 1 data 9", ok, rid, d); else n_pass++;
    endtask

    task automatic test_backpressure();
        int k; logic w, rid; logic [31:0] d; int lat; bit ok;
        apply_reset();
        set_r1(3'b111, 7'b0000000, 32'd5, 32'd7);
        #1;
        n_checks++; if (r1_ready !== 1'b1) $display("FAIL bp_grant: got %b expected 1", r1_ready); else n_pass++;
        @(posedge clk); #1;
        r1_valid = 0;
        set_r0(3'b000, 7'b0000000, 32'd2, 32'd2);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++; if (!rsp_valid) $display("FAIL bp_timeout: got no rsp_valid expected 1"); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'd5})
                $display("FAIL bp_hold: got v %b id %b data %0h expected 1/1/5", rsp_valid, rsp_id, rsp_data); else n_pass++;
            n_checks++; if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL bp_ready: got %b expected 00", {r0_ready, r1_ready}); else n_pass++;
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        #1;
        n_checks++; if (r0_ready !== 1'b0) $display("FAIL bp_hs_ready: got %b expected 0", r0_ready); else n_pass++;
        @(posedge clk); #1;
        rsp_ready = 0;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_drop: got %b expected 0", rsp_valid); else n_pass++;
        serve(w, rid, d, lat, ok);
        n_checks++; if (!ok || rid !== 1'b0 || d !== 32'd4)
            $display("FAIL bp_next: got ok %0d id %b data %0h expected id 0 data 4", ok, rid, d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_q[$];
        int acc[3];
        int n_acc, n_rsp, start;
        bit r0_seen, took;
        apply_reset();
        n_acc = 0; n_rsp = 0; r0_seen = 0;
        rsp_ready = 1;
        set_r1(3'b100, 7'b0000000, 32'd10, 32'd3);
        start = cyc;
        for (int c = 0; c < 40 && n_rsp < 3; c++) begin
            #1;
            took = 0;
            if (r0_ready) r0_seen = 1;
            if (r1_valid && r1_ready && n_acc < 3) begin
                acc[n_acc] = cyc;
                exp_q.push_back({1'b1, alu_ref(r1_fun3, r1_func7, r1_in1, r1_in2)});
                n_acc++;
                took = 1;
            end
            if (rsp_valid && exp_q.size() > 0) begin
                n_checks++; if ({rsp_id, rsp_data} !== exp_q[0])
                    $display("FAIL b2b_rsp: got id %b data %0h expected id %b data %0h", rsp_id, rsp_data, exp_q[0][32], exp_q[0][31:0]); else n_pass++;
                void'(exp_q.pop_front());
                n_rsp++;
            end
            @(posedge clk); #1;
            if (took) begin
                if (n_acc < 3) set_r1(3'b100, 7'b0000000, 32'(n_acc * 17), 32'd3);
                else r1_valid = 0;
            end
        end
        rsp_ready = 0;
        n_checks++; if (n_rsp != 3) $display("FAIL b2b_count: got %0d expected 3", n_rsp); else n_pass++;
        n_checks++; if (r0_seen) $display("FAIL b2b_r0_ready: got 1 expected 0"); else n_pass++;
        if (n_acc == 3) begin
            n_checks++; if (acc[0] != start) $display("FAIL b2b_first: got cycle %0d expected %0d", acc[0], start); else n_pass++;
            n_checks++; if (acc[1] - acc[0] != L + 3 || acc[2] - acc[1] != L + 3)
                $display("FAIL b2b_gap: got %0d %0d expected %0d", acc[1] - acc[0], acc[2] - acc[1], L + 3); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen; logic w, rid; logic [31:0] d; int lat; bit ok;
        apply_reset();
        set_r0(3'b000, 7'b0000000, 32'd1, 32'd2);
        #1;
        @(posedge clk); #1;
        r0_valid = 0;
        @(posedge clk); #1;
        n_checks++; if (dbg_state !== ST_BUSY) $display("FAIL rst_busy_pre: got %0d expected %0d", dbg_state, ST_BUSY); else n_pass++;
        rst_n = 0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL rst_busy_now: got v %b state %0d expected 0/%0d", rsp_valid, dbg_state, ST_IDLE); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        n_checks++; if (seen) $display("FAIL rst_busy_ghost: got rsp_valid 1 expected 0"); else n_pass++;
        set_r0(3'b000, 7'b0000000, 32'd3, 32'd4);
        serve(w, rid, d, lat, ok);
        n_checks++; if (!ok || rid !== 1'b0 || d !== 32'd7 || lat != L + 1)
            $display("FAIL rst_busy_next: got ok %0d id %b data %0h lat %0d expected id 0 data 7 lat %0d", ok, rid, d, lat, L + 1); else n_pass++;
    endtask

    task automatic test_latency3();
        int k;
        apply_reset();
        l3_r0_valid = 1; l3_r0_fun3 = 3'b000; l3_r0_func7 = 7'd0; l3_r0_in1 = 32'd5; l3_r0_in2 = 32'd7;
        #1;
        n_checks++; if (l3_r0_ready !== 1'b1) $display("FAIL lat3_grant: got %b expected 1", l3_r0_ready); else n_pass++;
        @(posedge clk); #1;
        l3_r0_valid = 0;
        k = 0;
        while (!l3_rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++; if (k != L3 + 1) $display("FAIL lat3_latency: got %0d expected %0d", k, L3 + 1); else n_pass++;
        n_checks++; if (l3_rsp_data !== 32'd12 || l3_rsp_id !== 1'b0)
            $display("FAIL lat3_rsp: got id %b data %0h expected 0/c", l3_rsp_id, l3_rsp_data); else n_pass++;
        l3_rsp_ready = 1;
        @(posedge clk); #1;
        l3_rsp_ready = 0;
        n_checks++; if (l3_rsp_valid !== 1'b0) $display("FAIL lat3_drop: got %b expected 0", l3_rsp_valid); else n_pass++;
    endtask

    // Model: pending ops per requester, one in flight, favoured side flips to the loser on accept.
    task automatic test_random();
        logic [2:0]  f3 [2];
        logic [6:0]  f7 [2];
        logic [31:0] a [2];
        logic [31:0] b [2];
        bit          pend [2];
        logic [32:0] exp_q[$];
        bit          m_busy, e0, e1, erv;
        int          m_ptr, m_t, done, win;
        apply_reset();
        m_busy = 0; m_ptr = 0; m_t = 0; done = 0;
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && c < 560 && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1;
                    f3[r] = 3'($urandom_range(0, 7));
                    f7[r] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                    a[r]  = $urandom;
                    b[r]  = $urandom;
                end
            end
            r0_valid = pend[0]; r0_fun3 = f3[0]; r0_func7 = f7[0]; r0_in1 = a[0]; r0_in2 = b[0];
            r1_valid = pend[1]; r1_fun3 = f3[1]; r1_func7 = f7[1]; r1_in1 = a[1]; r1_in2 = b[1];
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            e0  = !m_busy && pend[0] && (!pend[1] || m_ptr == 0);
            e1  = !m_busy && pend[1] && (!pend[0] || m_ptr == 1);
            erv = m_busy && (m_t >= L + 1);
            n_checks++; if ({r0_ready, r1_ready} !== {e0, e1})
                $display("FAIL rand_ready c%0d: got %b expected %b", c, {r0_ready, r1_ready}, {e0, e1}); else n_pass++;
            n_checks++; if (rsp_valid !== erv)
                $display("FAIL rand_rsp_valid c%0d: got %b expected %b", c, rsp_valid, erv); else n_pass++;
            if (erv && exp_q.size() > 0) begin
                n_checks++; if ({rsp_id, rsp_data} !== exp_q[0])
                    $display("FAIL rand_rsp c%0d: got id %b data %0h expected id %b data %0h", c, rsp_id, rsp_data, exp_q[0][32], exp_q[0][31:0]); else n_pass++;
            end
            if (erv && rsp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_busy = 0;
                done++;
            end else if (m_busy) begin
                m_t++;
            end
            if (e0 || e1) begin
                win = e1 ? 1 : 0;
                exp_q.push_back({e1, alu_ref(f3[win], f7[win], a[win], b[win])});
                m_ptr  = 1 - win;
                m_busy = 1;
                m_t    = 0;
            end
            if (r0_valid && r0_ready) pend[0] = 0;
            if (r1_valid && r1_ready) pend[1] = 0;
            @(posedge clk); #1;
        end
        rsp_ready = 0;
        r0_valid = 0; r1_valid = 0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rand_drain: got %0d left expected 0", exp_q.size()); else n_pass++;
        n_checks++; if (done < 40) $display("FAIL rand_volume: got %0d completions expected >= 40", done); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_two_requesters();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_latency3();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
